booth_mac_acc: RTL

- Downstream consumer of the radix-4 Booth multiplier datapath.
- Takes one signed 32-bit product per handshake and sums a programmed number of products into a wide accumulator (dot-product / MAC stage).
- Presents the final sum with a valid/ready output handshake.
- Sits between the multiplier's result port and the vector-result consumer.

---
 rtl/booth_mac_pkg.sv | 24 ++
 rtl/booth_mac_add.sv | 40 ++++
 rtl/booth_mac_acc.sv | 110 +++++++++++
 3 files changed

// File: rtl/booth_mac_pkg.sv
// Shared types and constants for the Booth MAC accumulator slice.
// Also holds the saturation limits used when BOOTH_MAC_SAT_EN is defined.
package booth_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PROD_W_D = 32;
  localparam int ACC_W_D  = 36;
  localparam int LEN_W_D  = 8;

  // Limits are returned 64 bits wide; callers slice to ACC_W (ACC_W <= 64).
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_mac_add.sv
// Combinational signed accumulator adder with overflow detect.
// Saturating result when BOOTH_MAC_SAT_EN is defined, two's-complement wrap otherwise.
module booth_mac_add
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_ovf
);

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_raw;

  assign w_ext = {{(ACC_W - PROD_W){i_prod[PROD_W-1]}}, i_prod};
  assign w_raw = i_acc + w_ext;

  // Same-sign operands whose sum flips sign are the only overflow case.
  assign o_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef BOOTH_MAC_SAT_EN
  localparam logic signed [63:0]      MAX64   = acc_max(ACC_W);
  localparam logic signed [63:0]      MIN64   = acc_min(ACC_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX = MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] SAT_MIN = MIN64[ACC_W-1:0];

  always_comb begin
    o_sum = w_raw;
    if (o_ovf) begin
      o_sum = i_acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/booth_mac_acc.sv
// Accumulates a programmed number of signed products and hands out the sum via valid/ready.
// Optional macro BOOTH_MAC_SAT_EN selects saturating instead of wrapping accumulation.
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int LEN_W  = LEN_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic [LEN_W-1:0]  count,
  output logic              ovf
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_count;
  logic [LEN_W-1:0]        r_len_q;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_start_ok;
  logic [LEN_W-1:0]        w_cnt_nxt;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_add_ovf;

  assign w_accept   = (r_state == ST_ACCUM) && prod_valid;
  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_cnt_nxt  = r_count + LEN_W'(1);
  assign w_last     = (w_cnt_nxt == r_len_q);

  booth_mac_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc  (r_acc),
    .i_prod (prod),
    .o_sum  (w_sum),
    .o_ovf  (w_add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run state is cleared on an accepted start; acc and ovf persist through IDLE until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len_q <= '0;
      r_ovf   <= 1'b0;
    end else if (w_start_ok) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len_q <= len;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum;
      r_count <= w_cnt_nxt;
      r_ovf   <= r_ovf | w_add_ovf;
    end
  end

  assign prod_ready = (r_state == ST_ACCUM);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign acc_out    = r_acc;
  assign count      = r_count;
  assign ovf        = r_ovf;

endmodule
